// File: rtl/mips_mdu.sv
// mips_mdu: iterative radix-2 multiply/divide unit owning Hi/Lo.
// One step per enabled clock, sign fix-up in a final FIX cycle.
module mips_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             start,
   input  logic             cancel,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state, state_nx;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   dsr;
   logic [WIDTH-1:0]   a_raw;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               dz;

   logic               go, accept, mt, last;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     msum, sh, diff;
   logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
   logic [WIDTH-1:0]   fhi, flo;

   assign go     = (state == IDLE) && start && !cancel;
   assign accept = go && !op[2];
   assign mt     = go && (op[2:1] == 2'b10);
   assign last   = (cnt == CW'(WIDTH - 1));
   assign busy   = (state != IDLE);

   assign a_neg = !op[0] && a[WIDTH-1];
   assign b_neg = !op[0] && b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // one shift-add and one restoring shift-subtract step
   always_comb begin
      msum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, dsr} : '0);
      mul_nx = {msum, acc[WIDTH-1:1]};
      sh     = acc[2*WIDTH-1:WIDTH-1];
      diff   = sh - {1'b0, dsr};
      if (diff[WIDTH])
         div_nx = {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // sign correction and divide-by-zero override for the FIX write
   always_comb begin
      prod = neg_q ? -acc : acc;
      fhi  = prod[2*WIDTH-1:WIDTH];
      flo  = prod[WIDTH-1:0];
      if (is_div) begin
         flo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         fhi = neg_r ? -acc[2*WIDTH-1:WIDTH]
                     : acc[2*WIDTH-1:WIDTH];
         if (dz) begin
            flo = '1;
            fhi = a_raw;
         end
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else if (en)
         state <= state_nx;
   end

   // next-state: cancel aborts, otherwise IDLE -> CALC -> FIX -> IDLE
   always_comb begin
      state_nx = state;
      if (cancel) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (last) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // operand latch, iteration datapath, Hi/Lo and done
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         acc    <= '0;
         dsr    <= '0;
         a_raw  <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else if (en) begin
         done <= 1'b0;
         if (mt) begin
            if (op[0]) lo <= a;
            else       hi <= a;
         end
         if (accept) begin
            acc    <= {{WIDTH{1'b0}}, a_mag};
            dsr    <= b_mag;
            a_raw  <= a;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= op[1] && (b == '0);
            cnt    <= '0;
         end
         if (state == CALC && !cancel) begin
            acc <= is_div ? div_nx : mul_nx;
            cnt <= cnt + CW'(1);
         end
         if (state == FIX && !cancel) begin
            hi   <= fhi;
            lo   <= flo;
            done <= 1'b1;
         end
      end
   end

endmodule
